// File: rtl/rv32i_types.sv
// Shared types for the RV32I front end.
//   fetch_pkt_t  : one fetched {pc, instr} pair, as produced by fetch and
//                  consumed by decode.
//   drop_state_e : tracks whether a wrong-path I-cache response is still due
//                  after a redirect.
package rv32i_types;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_pkt_t;

  typedef enum logic {
    DROP_IDLE = 1'b0,
    DROP_WAIT = 1'b1
  } drop_state_e;

endpackage

// File: rtl/iq_ram.sv
// Storage array for the instruction queue: DEPTH entries of fetch_pkt_t,
// one synchronous write port and one combinational read port.
// Ports:
//   clk_i    clock
//   rst_ni   asynchronous reset, active-low; clears every entry
//   we_i     write enable
//   waddr_i  write index
//   wdata_i  packet to store
//   raddr_i  read index
//   rdata_o  packet at raddr_i (combinational)
module iq_ram
  import rv32i_types::*;
#(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  fetch_pkt_t    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output fetch_pkt_t    rdata_o
);

  fetch_pkt_t mem_q [DEPTH];

  // Entry storage; cleared on reset so the read port never shows stale data.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/instr_queue.sv
// Decoupling FIFO between fetch and decode. Captures each {pc, instr}
// returned by the I-cache, presents them in order through valid/ready,
// asks fetch to freeze when nearly full, and discards queued plus
// wrong-path in-flight words on a redirect.
// Ports:
//   clk, rst (async, active-low)
//   flush              branch redirect; empties the queue
//   imem_busy          I-cache request outstanding
//   imem_resp          imem_rdata/resp_pc valid
//   freeze             to fetch: hold pc, no new request
//   iq_valid/iq_pc/iq_instr/iq_ready   head handshake to decode
//   iq_count           occupancy 0..DEPTH
//   iq_overflow        sticky: a response arrived while full
module instr_queue
  import rv32i_types::*;
#(
  parameter int DEPTH = 8,
  parameter int SKID  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     imem_busy,
  input  logic                     imem_resp,
  input  logic [31:0]              imem_rdata,
  input  logic [31:0]              resp_pc,
  output logic                     freeze,
  output logic                     iq_valid,
  output logic [31:0]              iq_pc,
  output logic [31:0]              iq_instr,
  input  logic                     iq_ready,
  output logic [$clog2(DEPTH):0]   iq_count,
  output logic                     iq_overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};
  localparam logic [PTR_W:0]   CNT_ONE  = {{PTR_W{1'b0}}, 1'b1};
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   FRZ_CNT  = (PTR_W+1)'(DEPTH - SKID);

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             ovf_q, ovf_d;
  drop_state_e      drop_q;

  logic        full_s;
  logic        accept_s;
  logic        enq_s;
  logic        deq_s;
  fetch_pkt_t  wr_pkt_s;
  fetch_pkt_t  rd_pkt_s;

  assign full_s   = (count_q == FULL_CNT);
  // A response is a candidate for storage unless it is a known wrong-path word.
  assign accept_s = imem_resp & (drop_q == DROP_IDLE) & ~flush;
  assign deq_s    = iq_valid & iq_ready;
  // Full only blocks the write when the head is not leaving in the same cycle.
  assign enq_s    = accept_s & (~full_s | deq_s);

  assign wr_pkt_s = '{pc: resp_pc, instr: imem_rdata};

  iq_ram #(.DEPTH(DEPTH)) u_ram (
    .clk_i   (clk),
    .rst_ni  (rst),
    .we_i    (enq_s),
    .waddr_i (tail_q),
    .wdata_i (wr_pkt_s),
    .raddr_i (head_q),
    .rdata_o (rd_pkt_s)
  );

  // Pointer, occupancy and overflow next-state; flush overrides everything.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    ovf_d   = ovf_q | (accept_s & full_s & ~deq_s);
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (enq_s) begin
        tail_d = tail_q + PTR_ONE;
      end else begin
        tail_d = tail_q;
      end
      if (deq_s) begin
        head_d = head_q + PTR_ONE;
      end else begin
        head_d = head_q;
      end
      case ({enq_s, deq_s})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // Queue state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // Wrong-path tracker: after a redirect with a request still in flight, the
  // next response belongs to the old path and must be thrown away.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_q <= DROP_IDLE;
    end else begin
      case (drop_q)
        DROP_IDLE: begin
          if (flush && imem_busy && !imem_resp) begin
            drop_q <= DROP_WAIT;
          end
        end
        DROP_WAIT: begin
          if (imem_resp) begin
            drop_q <= DROP_IDLE;
          end
        end
        default: drop_q <= DROP_IDLE;
      endcase
    end
  end

  assign iq_valid    = (count_q != '0);
  assign iq_pc       = iq_valid ? rd_pkt_s.pc    : 32'h0000_0000;
  assign iq_instr    = iq_valid ? rd_pkt_s.instr : 32'h0000_0000;
  assign iq_count    = count_q;
  assign freeze      = (count_q >= FRZ_CNT);
  assign iq_overflow = ovf_q;

endmodule

// File: tb/tb_instr_queue.sv
// Self-checking bench for instr_queue (DEPTH=8, SKID=2): directed scenarios
// followed by a short random run, with a scoreboard of expected head packets.
module tb_instr_queue;
  import rv32i_types::*;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        imem_busy;
  logic        imem_resp;
  logic [31:0] imem_rdata;
  logic [31:0] resp_pc;
  logic        freeze;
  logic        iq_valid;
  logic [31:0] iq_pc;
  logic [31:0] iq_instr;
  logic        iq_ready;
  logic [3:0]  iq_count;
  logic        iq_overflow;

  int n_checks;
  int n_errors;

  // Reference model state
  fetch_pkt_t sb[$];
  int         m_count;
  bit         m_drop;
  bit         m_ovf;

  instr_queue #(.DEPTH(8), .SKID(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .imem_busy   (imem_busy),
    .imem_resp   (imem_resp),
    .imem_rdata  (imem_rdata),
    .resp_pc     (resp_pc),
    .freeze      (freeze),
    .iq_valid    (iq_valid),
    .iq_pc       (iq_pc),
    .iq_instr    (iq_instr),
    .iq_ready    (iq_ready),
    .iq_count    (iq_count),
    .iq_overflow (iq_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus, check the head before the edge and the
  // state after it. Entered and left at posedge+1.
  task automatic step(input bit f, input bit busy, input bit resp,
                      input logic [31:0] pc, input logic [31:0] ins, input bit rdy);
    bit         m_deq;
    bit         m_enq;
    fetch_pkt_t p;
    flush = f; imem_busy = busy; imem_resp = resp;
    resp_pc = pc; imem_rdata = ins; iq_ready = rdy;
    #1;
    if (m_count != 0) begin
      check_eq("head_pc", {32'h0, iq_pc}, {32'h0, sb[0].pc});
      check_eq("head_instr", {32'h0, iq_instr}, {32'h0, sb[0].instr});
    end else begin
      check_eq("empty_pc", {32'h0, iq_pc}, 64'h0);
    end
    m_deq = (m_count != 0) && rdy;
    m_enq = resp && !m_drop && !f && ((m_count < 8) || m_deq);
    if (resp && !m_drop && !f && (m_count == 8) && !m_deq) m_ovf = 1'b1;
    if (f) begin
      sb.delete();
    end else begin
      if (m_deq) void'(sb.pop_front());
      if (m_enq) begin
        p.pc = pc; p.instr = ins;
        sb.push_back(p);
      end
    end
    m_count = sb.size();
    if (f) begin
      if (busy && !resp) m_drop = 1'b1;
      else if (resp) m_drop = 1'b0;
    end else if (m_drop && resp) begin
      m_drop = 1'b0;
    end
    @(posedge clk); #1;
    check_eq("count", {60'h0, iq_count}, 64'(m_count));
    check_eq("valid", {63'h0, iq_valid}, {63'h0, m_count != 0});
    check_eq("freeze", {63'h0, freeze}, {63'h0, m_count >= 6});
    check_eq("overflow", {63'h0, iq_overflow}, {63'h0, m_ovf});
  endtask

  task automatic model_reset();
    sb.delete();
    m_count = 0; m_drop = 1'b0; m_ovf = 1'b0;
  endtask

  function automatic logic [31:0] mk_ins(input logic [31:0] pc);
    return pc ^ 32'hA5A5_0013;
  endfunction

  initial begin
    logic [31:0] pc;
    n_checks = 0; n_errors = 0;
    rst = 1'b0; flush = 1'b0; imem_busy = 1'b0; imem_resp = 1'b0;
    imem_rdata = 32'h0; resp_pc = 32'h0; iq_ready = 1'b0;
    model_reset();

    // Reset state
    #2;
    check_eq("rst_valid", {63'h0, iq_valid}, 64'h0);
    check_eq("rst_count", {60'h0, iq_count}, 64'h0);
    check_eq("rst_freeze", {63'h0, freeze}, 64'h0);
    check_eq("rst_ovf", {63'h0, iq_overflow}, 64'h0);
    check_eq("rst_pc", {32'h0, iq_pc}, 64'h0);
    check_eq("rst_instr", {32'h0, iq_instr}, 64'h0);
    #10 rst = 1'b1;
    @(posedge clk); #1;

    // 1: three responses, no dequeue
    step(1'b0, 1'b1, 1'b1, 32'h6000_0000, mk_ins(32'h6000_0000), 1'b0);
    check_eq("t1_head", {32'h0, iq_pc}, 64'h6000_0000);
    step(1'b0, 1'b1, 1'b1, 32'h6000_0004, mk_ins(32'h6000_0004), 1'b0);
    step(1'b0, 1'b1, 1'b1, 32'h6000_0008, mk_ins(32'h6000_0008), 1'b0);
    check_eq("t1_count", {60'h0, iq_count}, 64'd3);
    check_eq("t1_freeze", {63'h0, freeze}, 64'h0);

    // 2: fill up, freeze at 6, overflow on the 9th
    step(1'b0, 1'b1, 1'b1, 32'h6000_000C, mk_ins(32'h6000_000C), 1'b0);
    step(1'b0, 1'b1, 1'b1, 32'h6000_0010, mk_ins(32'h6000_0010), 1'b0);
    check_eq("t2_nofreeze5", {63'h0, freeze}, 64'h0);
    step(1'b0, 1'b1, 1'b1, 32'h6000_0014, mk_ins(32'h6000_0014), 1'b0);
    check_eq("t2_freeze6", {63'h0, freeze}, 64'h1);
    step(1'b0, 1'b1, 1'b1, 32'h6000_0018, mk_ins(32'h6000_0018), 1'b0);
    step(1'b0, 1'b1, 1'b1, 32'h6000_001C, mk_ins(32'h6000_001C), 1'b0);
    check_eq("t2_full", {60'h0, iq_count}, 64'd8);
    check_eq("t2_noovf", {63'h0, iq_overflow}, 64'h0);
    step(1'b0, 1'b1, 1'b1, 32'h6000_0020, mk_ins(32'h6000_0020), 1'b0);
    check_eq("t2_count9", {60'h0, iq_count}, 64'd8);
    check_eq("t2_ovf", {63'h0, iq_overflow}, 64'h1);

    // 3: full with simultaneous enq and deq
    pc = 32'h6000_0040;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 1'b1, pc, mk_ins(pc), 1'b1);
      check_eq("t3_count", {60'h0, iq_count}, 64'd8);
      pc = pc + 32'd4;
    end

    // 4: drain to 5, flush with a request in flight
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    check_eq("t4_count5", {60'h0, iq_count}, 64'd5);
    step(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
    check_eq("t4_flushed", {60'h0, iq_count}, 64'd0);
    step(1'b0, 1'b0, 1'b1, 32'h6000_0014, mk_ins(32'h6000_0014), 1'b0);
    check_eq("t4_dropped", {60'h0, iq_count}, 64'd0);
    step(1'b0, 1'b0, 1'b1, 32'h6000_0100, mk_ins(32'h6000_0100), 1'b0);
    check_eq("t4_newhead", {32'h0, iq_pc}, 64'h6000_0100);

    // 5: flush coincident with response and ready
    step(1'b1, 1'b0, 1'b1, 32'h6000_0200, mk_ins(32'h6000_0200), 1'b1);
    check_eq("t5_count", {60'h0, iq_count}, 64'd0);
    step(1'b0, 1'b0, 1'b1, 32'h6000_0204, mk_ins(32'h6000_0204), 1'b0);
    check_eq("t5_nodrop", {60'h0, iq_count}, 64'd1);
    check_eq("t5_head", {32'h0, iq_pc}, 64'h6000_0204);

    // 6: async reset mid-stream at count 4
    for (int i = 0; i < 3; i++) begin
      pc = 32'h6000_0300 + 32'(i * 4);
      step(1'b0, 1'b1, 1'b1, pc, mk_ins(pc), 1'b0);
    end
    check_eq("t6_count4", {60'h0, iq_count}, 64'd4);
    #2;
    rst = 1'b0;
    flush = 1'b0; imem_busy = 1'b0; imem_resp = 1'b0; iq_ready = 1'b0;
    #1;
    check_eq("t6_valid", {63'h0, iq_valid}, 64'h0);
    check_eq("t6_count", {60'h0, iq_count}, 64'h0);
    check_eq("t6_freeze", {63'h0, freeze}, 64'h0);
    check_eq("t6_ovf", {63'h0, iq_overflow}, 64'h0);
    model_reset();
    #3 rst = 1'b1;
    @(posedge clk); #1;

    // Random traffic with wrap-around
    pc = 32'h6000_1000;
    for (int i = 0; i < 24; i++) begin
      step(($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 3) != 0), pc, $urandom, 1'($urandom_range(0, 1)));
      pc = pc + 32'd4;
    end
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
